// File: rtl/alu_op_sequencer_if.sv
// Command/strobe bundle between instruction decode, alu_op_sequencer and data_path.
// The decoder side uses modport master; the sequencer uses modport slave.
interface alu_op_sequencer_if;
  logic        start;
  logic        load_mode;
  logic [4:0]  op_in;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rd;
  logic [3:0]  rd_hi;
  logic        busy;
  logic        done;
  logic [4:0]  op;
  logic [15:0] reg_out;
  logic [15:0] reg_in;
  logic        y_in;
  logic        z_high_in;
  logic        z_low_in;
  logic        z_low_out;
  logic        z_high_out;
  logic        mdr_in;
  logic        mdr_out;
  logic        read;

  modport master (
    output start, load_mode, op_in, ra, rb, rd, rd_hi,
    input  busy, done, op, reg_out, reg_in, y_in, z_high_in, z_low_in,
           z_low_out, z_high_out, mdr_in, mdr_out, read
  );

  modport slave (
    input  start, load_mode, op_in, ra, rb, rd, rd_hi,
    output busy, done, op, reg_out, reg_in, y_in, z_high_in, z_low_in,
           z_low_out, z_high_out, mdr_in, mdr_out, read
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Control-step sequencer driving data_path strobes for one register-transfer command per start.
// Optional macro ZHIGH_WB_EN adds a WB_HI step writing Zhigh to rd_hi for wide ops.
module alu_op_sequencer #(
  parameter logic [4:0] UNARY_OP0 = 5'b10001,
  parameter logic [4:0] UNARY_OP1 = 5'b10010,
  parameter logic [4:0] WIDE_OP0  = 5'b01111,
  parameter logic [4:0] WIDE_OP1  = 5'b10000
) (
  input logic               Clock,
  input logic               clear,
  alu_op_sequencer_if.slave sq
);

  typedef enum logic [2:0] {
    IDLE,
    LD_MDR,
    LD_REG,
    OP_Y,
    EXEC,
    WB_LO,
`ifdef ZHIGH_WB_EN
    WB_HI,
`endif
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  op_q;
  logic [3:0]  ra_q, rb_q, rd_q;
`ifdef ZHIGH_WB_EN
  logic [3:0]  rd_hi_q;
`endif

  logic        busy_c, done_c, y_in_c, z_high_in_c, z_low_in_c;
  logic        z_low_out_c, z_high_out_c, mdr_in_c, mdr_out_c, read_c;
  logic [4:0]  op_c;
  logic [15:0] reg_out_c, reg_in_c;

  function automatic logic is_unary(input logic [4:0] code);
    return (code == UNARY_OP0) || (code == UNARY_OP1);
  endfunction

`ifdef ZHIGH_WB_EN
  function automatic logic is_wide(input logic [4:0] code);
    return (code == WIDE_OP0) || (code == WIDE_OP1);
  endfunction
`endif

  function automatic logic [15:0] onehot(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command fields are only meaningful while busy, so they carry no reset.
  always_ff @(posedge Clock) begin
    if (state_q == IDLE && sq.start) begin
      op_q    <= sq.op_in;
      ra_q    <= sq.ra;
      rb_q    <= sq.rb;
      rd_q    <= sq.rd;
`ifdef ZHIGH_WB_EN
      rd_hi_q <= sq.rd_hi;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_c       = (state_q != IDLE);
    done_c       = 1'b0;
    op_c         = 5'b0;
    reg_out_c    = 16'h0000;
    reg_in_c     = 16'h0000;
    y_in_c       = 1'b0;
    z_high_in_c  = 1'b0;
    z_low_in_c   = 1'b0;
    z_low_out_c  = 1'b0;
    z_high_out_c = 1'b0;
    mdr_in_c     = 1'b0;
    mdr_out_c    = 1'b0;
    read_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (sq.start) begin
          if (sq.load_mode)          state_d = LD_MDR;
          else if (is_unary(sq.op_in)) state_d = EXEC;
          else                       state_d = OP_Y;
        end
      end
      LD_MDR: begin
        read_c   = 1'b1;
        mdr_in_c = 1'b1;
        state_d  = LD_REG;
      end
      LD_REG: begin
        mdr_out_c = 1'b1;
        reg_in_c  = onehot(rd_q);
        state_d   = DONE;
      end
      OP_Y: begin
        reg_out_c = onehot(ra_q);
        y_in_c    = 1'b1;
        state_d   = EXEC;
      end
      EXEC: begin
        // Unary ops skip the Y load, so the single operand goes straight onto the bus here.
        op_c        = op_q;
        reg_out_c   = is_unary(op_q) ? onehot(ra_q) : onehot(rb_q);
        z_high_in_c = 1'b1;
        z_low_in_c  = 1'b1;
        state_d     = WB_LO;
      end
      WB_LO: begin
        z_low_out_c = 1'b1;
        reg_in_c    = onehot(rd_q);
`ifdef ZHIGH_WB_EN
        state_d     = is_wide(op_q) ? WB_HI : DONE;
`else
        state_d     = DONE;
`endif
      end
`ifdef ZHIGH_WB_EN
      WB_HI: begin
        z_high_out_c = 1'b1;
        reg_in_c     = onehot(rd_hi_q);
        state_d      = DONE;
      end
`endif
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sq.busy       = busy_c;
  assign sq.done       = done_c;
  assign sq.op         = op_c;
  assign sq.reg_out    = reg_out_c;
  assign sq.reg_in     = reg_in_c;
  assign sq.y_in       = y_in_c;
  assign sq.z_high_in  = z_high_in_c;
  assign sq.z_low_in   = z_low_in_c;
  assign sq.z_low_out  = z_low_out_c;
  assign sq.z_high_out = z_high_out_c;
  assign sq.mdr_in     = mdr_in_c;
  assign sq.mdr_out    = mdr_out_c;
  assign sq.read       = read_c;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed spec scenarios plus randomized commands
// checked every cycle against a queue-based model of the per-command strobe schedule.
module tb_alu_op_sequencer;

  localparam logic [4:0] U0 = 5'b10001;
  localparam logic [4:0] U1 = 5'b10010;
  localparam logic [4:0] W0 = 5'b01111;
  localparam logic [4:0] W1 = 5'b10000;
`ifdef ZHIGH_WB_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic Clock = 1'b0;
  logic clear = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_op_sequencer_if bus();

  alu_op_sequencer dut (
    .Clock (Clock),
    .clear (clear),
    .sq    (bus.slave)
  );

  initial forever #5 Clock = ~Clock;

  // Output vector layout: busy,done,op[5],reg_out[16],reg_in[16],y_in,z_high_in,z_low_in,
  // z_low_out,z_high_out,mdr_in,mdr_out,read
  logic [46:0] dut_vec;
  assign dut_vec = {bus.busy, bus.done, bus.op, bus.reg_out, bus.reg_in, bus.y_in,
                    bus.z_high_in, bus.z_low_in, bus.z_low_out, bus.z_high_out,
                    bus.mdr_in, bus.mdr_out, bus.read};

  function automatic logic [15:0] oh(input logic [3:0] i);
    logic [15:0] one;
    one = 16'h0001;
    return one << i;
  endfunction

  function automatic logic [46:0] mk(input bit dn, input logic [4:0] op,
                                     input logic [15:0] ro, input logic [15:0] ri,
                                     input bit y, input bit zhi, input bit zli,
                                     input bit zlo, input bit zho, input bit mi,
                                     input bit mo, input bit rdd);
    return {1'b1, dn, op, ro, ri, y, zhi, zli, zlo, zho, mi, mo, rdd};
  endfunction

  // Reference model: on acceptance the whole per-cycle schedule of the command is queued.
  logic [46:0] exp_q[$];
  logic [46:0] cur = '0;

  always @(posedge Clock or posedge clear) begin
    if (clear) begin
      exp_q.delete();
      cur = '0;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else if (!cur[46] && bus.start === 1'b1) begin
      if (bus.load_mode) begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        exp_q.push_back(mk(0, 0, 0, oh(bus.rd), 0, 0, 0, 0, 0, 0, 1, 0));
      end else if (bus.op_in == U0 || bus.op_in == U1) begin
        exp_q.push_back(mk(0, bus.op_in, oh(bus.ra), 0, 0, 1, 1, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, oh(bus.rd), 0, 0, 0, 1, 0, 0, 0, 0));
      end else begin
        exp_q.push_back(mk(0, 0, oh(bus.ra), 0, 1, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, bus.op_in, oh(bus.rb), 0, 0, 1, 1, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, oh(bus.rd), 0, 0, 0, 1, 0, 0, 0, 0));
        if (HI_EN && (bus.op_in == W0 || bus.op_in == W1))
          exp_q.push_back(mk(0, 0, 0, oh(bus.rd_hi), 0, 0, 0, 0, 1, 0, 0, 0));
      end
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      cur = exp_q.pop_front();
    end else begin
      cur = '0;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge Clock) begin
    if (cmp_en && !clear) begin
      checks++;
      if (dut_vec !== cur) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, dut_vec, cur);
      end
    end
  end

  task automatic chk(input string name, input logic [46:0] act, input logic [46:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  logic [46:0] snap [1:12];

  task automatic run_cmd(input bit ld, input logic [4:0] opc, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] d, input logic [3:0] dh,
                         input int hold, output int lat);
    @(negedge Clock);
    #1;
    bus.start = 1'b1; bus.load_mode = ld; bus.op_in = opc;
    bus.ra = a; bus.rb = b; bus.rd = d; bus.rd_hi = dh;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clock);
      snap[k] = dut_vec;
      if (bus.done === 1'b1 && lat < 0) lat = k;
      if (k == hold) begin
        #1;
        bus.start = 1'b0;
      end
    end
    if (lat < 0) chk("done_timeout", 47'd0, 47'd1);
  endtask

  int lat;
  logic [46:0] zho_any;

  initial begin
    bus.start = 0; bus.load_mode = 0; bus.op_in = 0;
    bus.ra = 0; bus.rb = 0; bus.rd = 0; bus.rd_hi = 0;
    repeat (2) @(negedge Clock);
    chk("reset_outputs", dut_vec, 47'd0);
    #1 clear = 1'b0;
    cmp_en = 1'b1;

    // Load into R2
    run_cmd(1, 5'b0, 0, 0, 2, 0, 1, lat);
    chk("load_T1_read_mdrin", {45'd0, snap[1][2], snap[1][0]}, 47'd3);
    chk("load_T2_reg_in", {31'd0, snap[2][23:8]}, 47'h0004);
    chk("load_T2_mdr_out", {46'd0, snap[2][1]}, 47'd1);
    chk("load_latency", 47'(lat), 47'd3);

    // ROR R3 <= R1, R2
    run_cmd(0, 5'b00111, 1, 2, 3, 0, 1, lat);
    chk("ror_T1_reg_out", {31'd0, snap[1][39:24]}, 47'h0002);
    chk("ror_T1_y_in", {46'd0, snap[1][7]}, 47'd1);
    chk("ror_T2_op", {42'd0, snap[2][44:40]}, 47'h07);
    chk("ror_T2_reg_out", {31'd0, snap[2][39:24]}, 47'h0004);
    chk("ror_T2_zin", {45'd0, snap[2][6:5]}, 47'd3);
    chk("ror_T3_reg_in", {31'd0, snap[3][23:8]}, 47'h0008);
    chk("ror_latency", 47'(lat), 47'd4);

    // Unary R6 <= op R5
    run_cmd(0, U0, 5, 0, 6, 0, 1, lat);
    chk("unary_T1_no_y", {46'd0, snap[1][7]}, 47'd0);
    chk("unary_T1_reg_out", {31'd0, snap[1][39:24]}, 47'h0020);
    chk("unary_latency", 47'(lat), 47'd3);

    // Wide op
    run_cmd(0, W0, 1, 2, 3, 4, 1, lat);
    zho_any = '0;
    for (int k = 1; k <= 12; k++) zho_any[0] = zho_any[0] | snap[k][3];
`ifdef ZHIGH_WB_EN
    chk("wide_T4_reg_in", {31'd0, snap[4][23:8]}, 47'h0010);
    chk("wide_T4_zhigh_out", {46'd0, snap[4][3]}, 47'd1);
    chk("wide_latency", 47'(lat), 47'd5);
`else
    chk("wide_no_zhigh_out", zho_any, 47'd0);
    chk("wide_latency", 47'(lat), 47'd4);
`endif

    // Start held high through the whole command: not re-accepted
    run_cmd(0, 5'b00011, 7, 8, 9, 0, 4, lat);
    chk("busy_start_latency", 47'(lat), 47'd4);
    chk("busy_start_idle_after", {45'd0, snap[5][46], snap[6][46]}, 47'd0);

    // Clear in EXEC
    @(negedge Clock);
    #1;
    bus.start = 1; bus.load_mode = 0; bus.op_in = 5'b00101; bus.ra = 1; bus.rb = 2; bus.rd = 3;
    @(negedge Clock);
    #1 bus.start = 0;
    @(negedge Clock);
    chk("clr_pre_exec_op", {42'd0, bus.op}, 47'h05);
    #1 clear = 1'b1;
    #1;
    chk("clr_async_outputs", dut_vec, 47'd0);
    #1 clear = 1'b0;
    run_cmd(1, 5'b0, 0, 0, 11, 0, 1, lat);
    chk("clr_after_latency", 47'(lat), 47'd3);
    chk("clr_after_reg_in", {31'd0, snap[2][23:8]}, 47'h0800);

    // Randomized traffic, occasional async clear
    for (int c = 0; c < 800; c++) begin
      @(negedge Clock);
      #1;
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.load_mode = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0:       bus.op_in = ($urandom_range(0, 1) != 0) ? U0 : U1;
        1:       bus.op_in = ($urandom_range(0, 1) != 0) ? W0 : W1;
        default: bus.op_in = 5'($urandom);
      endcase
      bus.ra = 4'($urandom); bus.rb = 4'($urandom);
      bus.rd = 4'($urandom); bus.rd_hi = 4'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        clear = 1'b1;
        #2 clear = 1'b0;
      end
    end
    @(negedge Clock);
    #1 bus.start = 0;
    repeat (8) @(negedge Clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
